// File: rtl/eeprom_bus_pkg.sv
// -----------------------------------------------------------------------------
// eeprom_bus_pkg
// Shared definitions for eeprom_bus_master: the controller state encoding,
// default timing/poll parameters and small decode helpers that map a state to
// the 28256 bus strobes it asserts.
// -----------------------------------------------------------------------------
package eeprom_bus_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;

  // Default bus timing and polling limits.
  localparam int DEF_READ_WAIT   = 3;     // cycles with oe_n low before sampling
  localparam int DEF_WRITE_PULSE = 2;     // cycles with we_n low per write
  localparam int DEF_POLL_LIMIT  = 1000;  // data-poll reads per write before timeout

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_STROBE,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_POLL_STROBE,
    ST_POLL_GAP,
    ST_RESP
  } state_e;

  // Chip enable is active for every state that touches the device.
  function automatic logic ce_active(state_e s);
    return s inside {ST_RD_STROBE, ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD,
                     ST_POLL_STROBE};
  endfunction

  // Output enable is active only while the device is being read.
  function automatic logic oe_active(state_e s);
    return s inside {ST_RD_STROBE, ST_POLL_STROBE};
  endfunction

  // Write enable is active only during the write pulse itself.
  function automatic logic we_active(state_e s);
    return s == ST_WR_PULSE;
  endfunction

  // The master owns the data bus from setup through hold of a write.
  function automatic logic drive_active(state_e s);
    return s inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD};
  endfunction

endpackage

// File: rtl/eeprom_bus_master.sv
// -----------------------------------------------------------------------------
// eeprom_bus_master
// Single-request bus master for a 28256-style parallel EEPROM. A request is
// accepted in IDLE, executed as a timed read strobe or as a write pulse
// followed by bit-7 data polling, and completed with a one-cycle response.
//
// Configuration macro: EEPROM_BUS_MASTER_WRITE_EN
//   defined   : full write path (setup / pulse / hold / data polling)
//   undefined : writes are accepted and answered with rsp_error=1 one cycle
//               later; mem_we_n stays high and mem_data is never driven.
//
// Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_write            1 = write, 0 = read
//   req_addr, req_wdata  byte address and write data, latched on acceptance
//   rsp_valid            one-cycle completion pulse
//   rsp_rdata            read data, or last polled byte of a write
//   rsp_error            write timeout or write path disabled
//   mem_addr, mem_data   device address and bidirectional data bus
//   mem_ce_n/oe_n/we_n   active-low device strobes (registered, glitch free)
// -----------------------------------------------------------------------------
module eeprom_bus_master
  import eeprom_bus_pkg::*;
#(
  parameter int READ_WAIT   = DEF_READ_WAIT,
  parameter int WRITE_PULSE = DEF_WRITE_PULSE,
  parameter int POLL_LIMIT  = DEF_POLL_LIMIT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n
);

  // Shared strobe/pulse timer; holds remaining cycles minus one.
  localparam logic [3:0] RD_LOAD = 4'(READ_WAIT - 1);

  state_e              state_q, state_d;
  logic [3:0]          tmr_q, tmr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                error_q, error_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;

`ifdef EEPROM_BUS_MASTER_WRITE_EN
  localparam int         PCW     = $clog2(POLL_LIMIT + 1);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_PULSE - 1);

  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [PCW-1:0]      poll_q, poll_d;
  logic                we_n_q, we_n_d;
  logic                drive_q, drive_d;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d = state_q;
    tmr_d   = tmr_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    error_d = error_q;
`ifdef EEPROM_BUS_MASTER_WRITE_EN
    wdata_d = wdata_q;
    poll_d  = poll_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          error_d = 1'b0;
          if (!req_write) begin
            state_d = ST_RD_STROBE;
            tmr_d   = RD_LOAD;
          end else begin
`ifdef EEPROM_BUS_MASTER_WRITE_EN
            wdata_d = req_wdata;
            poll_d  = '0;
            state_d = ST_WR_SETUP;
`else
            // Write path not built: refuse the write without touching the bus.
            rdata_d = '0;
            error_d = 1'b1;
            state_d = ST_RESP;
`endif
          end
        end
      end

      ST_RD_STROBE: begin
        if (tmr_q == 4'd0) begin
          rdata_d = mem_data;
          state_d = ST_RESP;
        end else begin
          tmr_d = tmr_q - 4'd1;
        end
      end

`ifdef EEPROM_BUS_MASTER_WRITE_EN
      ST_WR_SETUP: begin
        state_d = ST_WR_PULSE;
        tmr_d   = WR_LOAD;
      end

      ST_WR_PULSE: begin
        if (tmr_q == 4'd0) begin
          state_d = ST_WR_HOLD;
        end else begin
          tmr_d = tmr_q - 4'd1;
        end
      end

      ST_WR_HOLD: begin
        state_d = ST_POLL_STROBE;
        tmr_d   = RD_LOAD;
      end

      ST_POLL_STROBE: begin
        if (tmr_q == 4'd0) begin
          rdata_d = mem_data;
          poll_d  = poll_q + 1'b1;
          // While the internal write is in progress the device returns the
          // complement of the written bit 7.
          if (mem_data[7] == wdata_q[7]) begin
            state_d = ST_RESP;
          end else if (poll_q == PCW'(POLL_LIMIT - 1)) begin
            error_d = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_POLL_GAP;
          end
        end else begin
          tmr_d = tmr_q - 4'd1;
        end
      end

      ST_POLL_GAP: begin
        state_d = ST_POLL_STROBE;
        tmr_d   = RD_LOAD;
      end
`endif

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    // Strobes are decoded from the next state and registered, so the bus pins
    // change exactly when the state does and never glitch.
    ce_n_d = !ce_active(state_d);
    oe_n_d = !oe_active(state_d);
`ifdef EEPROM_BUS_MASTER_WRITE_EN
    we_n_d  = !we_active(state_d);
    drive_d = drive_active(state_d);
`endif
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments keep every flop sampling the pre-edge
    // value of its neighbours, independent of statement order.
    if (reset) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
    end
  end

`ifdef EEPROM_BUS_MASTER_WRITE_EN
  // Reset drops the write pulse and releases the bus on the very next edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      wdata_q <= '0;
      poll_q  <= '0;
      we_n_q  <= 1'b1;
      drive_q <= 1'b0;
    end else begin
      wdata_q <= wdata_d;
      poll_q  <= poll_d;
      we_n_q  <= we_n_d;
      drive_q <= drive_d;
    end
  end

  assign mem_we_n = we_n_q;
  assign mem_data = drive_q ? wdata_q : {DATA_W{1'bz}};
`else
  assign mem_we_n = 1'b1;
  assign mem_data = {DATA_W{1'bz}};

  // Write data and write timing are meaningless without the write path.
  logic unused_write_cfg;
  assign unused_write_cfg = ^{req_wdata, WRITE_PULSE[0], POLL_LIMIT[0]};
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;
  assign mem_addr  = addr_q;
  assign mem_ce_n  = ce_n_q;
  assign mem_oe_n  = oe_n_q;

endmodule

// File: tb/tb_eeprom_bus_master.sv
// -----------------------------------------------------------------------------
// tb_eeprom_bus_master
// Self-checking bench for eeprom_bus_master. A behavioural 28256 device model
// answers reads and emulates the internal write cycle (bit 7 inverted while
// busy); a reference array predicts read data and write outcomes. Expectations
// follow the build selected by EEPROM_BUS_MASTER_WRITE_EN.
// -----------------------------------------------------------------------------
module tb_eeprom_bus_master;

  localparam int RW = 3;  // READ_WAIT
  localparam int WP = 2;  // WRITE_PULSE
  localparam int PL = 8;  // POLL_LIMIT

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [14:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_error;
  logic [14:0] mem_addr;
  wire  [7:0]  mem_data;
  logic        mem_ce_n;
  logic        mem_oe_n;
  logic        mem_we_n;

  always #5 clock = ~clock;

  eeprom_bus_master #(
    .READ_WAIT  (RW),
    .WRITE_PULSE(WP),
    .POLL_LIMIT (PL)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_ce_n (mem_ce_n),
    .mem_oe_n (mem_oe_n),
    .mem_we_n (mem_we_n)
  );

  // ---------------------------------------------------------------------------
  // Device model
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] pattern(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'hB5;  // 15'h0010 -> 8'hA5
  endfunction

  logic [7:0] dev_mem [0:32767];
  bit         dev_wr  [0:32767];
  int         busy_cnt = 0;
  int         busy_cfg = 0;
  bit         hang     = 1'b0;
  logic [7:0] busy_byte = 8'h00;
  logic       prev_we = 1'b1;
  logic [7:0] dev_out;

  assign dev_out  = (hang || busy_cnt != 0) ? {~busy_byte[7], busy_byte[6:0]}
                  : (dev_wr[mem_addr] ? dev_mem[mem_addr] : pattern(mem_addr));
  assign mem_data = (!mem_ce_n && !mem_oe_n) ? dev_out : 8'bz;

  // Write commits on the rising edge of we_n while the chip is selected.
  always @(negedge clock) begin
    if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (!mem_ce_n && mem_we_n && !prev_we) begin
      dev_mem[mem_addr] <= mem_data;
      dev_wr[mem_addr]  <= 1'b1;
      busy_byte         <= mem_data;
      busy_cnt          <= busy_cfg;
    end
    prev_we <= mem_we_n;
  end

  // ---------------------------------------------------------------------------
  // Bus monitor: strobe overlap, read strobes, we_n low cycles, poll gaps
  // ---------------------------------------------------------------------------
  int   overlap_cnt = 0;
  int   strobe_total = 0;
  int   we_low_total = 0;
  int   oe_high_run = 0;
  int   last_gap = 0;
  logic prev_oe = 1'b1;

  always @(negedge clock) begin
    if (!mem_oe_n && !mem_we_n) overlap_cnt <= overlap_cnt + 1;
    if (!mem_we_n) we_low_total <= we_low_total + 1;
    if (mem_oe_n) begin
      oe_high_run <= oe_high_run + 1;
    end else begin
      if (prev_oe) begin
        strobe_total <= strobe_total + 1;
        last_gap     <= oe_high_run;
      end
      oe_high_run <= 0;
    end
    prev_oe <= mem_oe_n;
  end

  // ---------------------------------------------------------------------------
  // Checking and reference model
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] ref_mem [int];

  function automatic logic [7:0] exp_read(input logic [14:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pattern(a);
  endfunction

  // One complete request: returns response data, error and the latency in
  // edges from the acceptance edge to the edge that samples rsp_valid high.
  task automatic do_req(input bit wr, input logic [14:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic er, output int lat);
    int guard;
    @(negedge clock);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    guard = 0;
    while (!req_ready && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 100) check("accept_timeout", 32'(guard), 32'd0);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    check("addr_latched", 32'(mem_addr), 32'(a));
    lat = 1;
    while (!rsp_valid && lat < 2000) begin
      @(negedge clock);
      lat++;
    end
    if (!rsp_valid) check("rsp_timeout", 32'(lat), 32'd0);
    rd = rsp_rdata;
    er = rsp_error;
    @(negedge clock);
    check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
  endtask

  logic [7:0]  rd, rd1, d;
  logic        er;
  logic [14:0] a;
  int          lat, n, n1, s0, w0, guard;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'h00);
    check("rst_rsp_error", 32'(rsp_error), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_strobes", 32'({mem_ce_n, mem_oe_n, mem_we_n}), 32'b111);
    reset = 1'b0;
    @(negedge clock);
    check("rst_req_ready", 32'(req_ready), 32'd1);

    // Preloaded read: latency READ_WAIT+1.
    do_req(1'b0, 15'h0010, 8'h00, rd, er, lat);
    check("rd_preload_data", 32'(rd), 32'hA5);
    check("rd_preload_err", 32'(er), 32'd0);
    check("rd_latency", 32'(lat), 32'(RW + 1));

`ifdef EEPROM_BUS_MASTER_WRITE_EN
    // Write with a 20-cycle internal busy time: several polls, then success.
    busy_cfg = 20;
    s0 = strobe_total;
    w0 = we_low_total;
    do_req(1'b1, 15'h7FFF, 8'h3C, rd, er, lat);
    ref_mem[32'h7FFF] = 8'h3C;
    check("wr_data", 32'(rd), 32'h3C);
    check("wr_err", 32'(er), 32'd0);
    check("wr_we_low_cycles", 32'(we_low_total - w0), 32'(WP));
    check("wr_multi_poll", 32'((strobe_total - s0) >= 2), 32'd1);
    check("wr_poll_gap", 32'(last_gap), 32'd1);
    do_req(1'b0, 15'h7FFF, 8'h00, rd, er, lat);
    check("wr_readback", 32'(rd), 32'h3C);

    // Device never finishes: exactly POLL_LIMIT polls, then timeout.
    hang     = 1'b1;
    busy_cfg = 0;
    s0 = strobe_total;
    do_req(1'b1, 15'h0123, 8'h81, rd, er, lat);
    ref_mem[32'h0123] = 8'h81;
    check("to_polls", 32'(strobe_total - s0), 32'(PL));
    check("to_err", 32'(er), 32'd1);
    check("to_last_byte", 32'(rd), 32'h01);
    hang = 1'b0;
    do_req(1'b0, 15'h0123, 8'h00, rd, er, lat);
    check("to_readback", 32'(rd), 32'h81);
    check("to_read_err", 32'(er), 32'd0);

    // Reset in the middle of the write pulse.
    @(negedge clock);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 15'h0200;
    req_wdata = 8'h55;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    guard = 0;
    while (mem_we_n && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    check("pulse_reached", 32'(mem_we_n), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("rstwr_strobes", 32'({mem_ce_n, mem_oe_n, mem_we_n}), 32'b111);
    check("rstwr_rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("rstwr_ready", 32'(req_ready), 32'd1);
    do_req(1'b0, 15'h0200, 8'h00, rd, er, lat);
    check("rstwr_no_commit", 32'(rd), 32'(pattern(15'h0200)));
`else
    // Write path absent: immediate error response, bus untouched.
    s0 = strobe_total;
    w0 = we_low_total;
    do_req(1'b1, 15'h0010, 8'h5A, rd, er, lat);
    check("wrdis_latency", 32'(lat), 32'd1);
    check("wrdis_err", 32'(er), 32'd1);
    check("wrdis_data", 32'(rd), 32'h00);
    check("wrdis_we_low", 32'(we_low_total - w0), 32'd0);
    check("wrdis_no_strobe", 32'(strobe_total - s0), 32'd0);
    do_req(1'b0, 15'h0010, 8'h00, rd, er, lat);
    check("wrdis_readback", 32'(rd), 32'hA5);
`endif

    // Reset in the middle of a read strobe.
    @(negedge clock);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 15'h0444;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("rstrd_strobes", 32'({mem_ce_n, mem_oe_n, mem_we_n}), 32'b111);
    check("rstrd_addr", 32'(mem_addr), 32'd0);
    check("rstrd_rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("rstrd_ready", 32'(req_ready), 32'd1);

    // Back-to-back reads with req_valid held high.
    @(negedge clock);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 15'h0033;
    @(posedge clock);
    @(negedge clock);
    req_addr = 15'h0034;
    n  = 1;
    n1 = 0;
    rd1 = 8'h00;
    while (!req_ready && n < 50) begin
      if (rsp_valid) begin
        n1  = n;
        rd1 = rsp_rdata;
      end
      @(negedge clock);
      n++;
    end
    check("b2b_first_lat", 32'(n1), 32'(RW + 1));
    check("b2b_first_data", 32'(rd1), 32'(exp_read(15'h0033)));
    check("b2b_second_accept", 32'(n), 32'(RW + 2));
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("b2b_second_lat", 32'(n), 32'(RW + 1));
    check("b2b_second_data", 32'(rsp_rdata), 32'(exp_read(15'h0034)));

    // Randomised mix over a small address window so writes get read back.
    for (int i = 0; i < 24; i++) begin
      a = 15'h0100 + 15'($urandom_range(0, 7));
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
`ifdef EEPROM_BUS_MASTER_WRITE_EN
        busy_cfg = $urandom_range(0, 10);
        do_req(1'b1, a, d, rd, er, lat);
        ref_mem[int'(a)] = d;
        check("rnd_wr_data", 32'(rd), 32'(d));
        check("rnd_wr_err", 32'(er), 32'd0);
`else
        do_req(1'b1, a, d, rd, er, lat);
        check("rnd_wr_err", 32'(er), 32'd1);
        check("rnd_wr_lat", 32'(lat), 32'd1);
`endif
      end else begin
        do_req(1'b0, a, 8'h00, rd, er, lat);
        check("rnd_rd_data", 32'(rd), 32'(exp_read(a)));
        check("rnd_rd_err", 32'(er), 32'd0);
        check("rnd_rd_lat", 32'(lat), 32'(RW + 1));
      end
    end

    check("no_oe_we_overlap", 32'(overlap_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
